// File: rtl/mem_pkg.sv
// Shared types and widths for the load/store sequencer.
package mem_pkg;

   localparam int WORD_W    = 16;
   localparam int REG_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      WB   = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_unit.sv
// Load/store sequencer between decode and the register file memory port.
// Runs one word-sized load or store at a time over a single-outstanding
// valid/ready bus. Instruction fetch is simply a load into register 0 (IR).
//
// Optional feature: define MEM_UNIT_TIMEOUT_EN to abandon a bus access that
// waits TIMEOUT_CYCLES cycles without bus_ready (fault pulse, no writeback).
// Without it fault is held at 0 and the bus wait is unbounded.
//
// Handshakes: a request is taken on a rising edge where req_valid and
// req_ready are both 1; a bus access completes on a rising edge where
// bus_valid and bus_ready are both 1. bus_valid, bus_we, bus_addr and
// bus_wdata hold steady from assertion until that completing edge, and
// bus_ready is ignored whenever bus_valid is 0.
module mem_unit
   import mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_store,
   input  logic [REG_IDX_W-1:0] req_reg,
   input  logic [WORD_W-1:0]    req_addr,
   output logic [REG_IDX_W-1:0] memory_index,
   output logic [WORD_W-1:0]    memory_load,
   output logic                 memory_load_en,
   input  logic [WORD_W-1:0]    memory_store,
   output logic                 bus_valid,
   input  logic                 bus_ready,
   output logic                 bus_we,
   output logic [WORD_W-1:0]    bus_addr,
   output logic [WORD_W-1:0]    bus_wdata,
   input  logic [WORD_W-1:0]    bus_rdata,
   output logic                 done,
   output logic                 fault,
   output mem_state_t           state_dbg
);

   // The wait counter compare below needs at least one BUS cycle.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("mem_unit: TIMEOUT_CYCLES must be in 1..65535");
   end

   mem_state_t           state;
   mem_state_t           state_next;
   logic [REG_IDX_W-1:0] reg_q;
   logic                 accept;
   logic                 store_retire;
   logic                 load_capture;
   logic                 timeout;

`ifdef MEM_UNIT_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;
`endif

   assign state_dbg = state;

   // Register index to the register file: follows the incoming request while
   // idle so memory_store is already valid in the acceptance cycle.
   assign memory_index = (state == IDLE) ? req_reg : reg_q;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and the single-cycle events that drive the registers.
   always_comb begin
      state_next   = state;
      accept       = 1'b0;
      store_retire = 1'b0;
      load_capture = 1'b0;
      timeout      = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept     = 1'b1;
               state_next = BUS;
            end
         end
         BUS: begin
            if (bus_ready) begin
               if (bus_we) begin
                  store_retire = 1'b1;
                  state_next   = IDLE;
               end else begin
                  load_capture = 1'b1;
                  state_next   = WB;
               end
            end
`ifdef MEM_UNIT_TIMEOUT_EN
            else if (wait_cnt == CNT_LAST) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end
`endif
         end
         WB: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered outputs and request latches. Store data is taken from the
   // register file at acceptance, so later writes to that register during the
   // bus wait do not reach bus_wdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready      <= 1'b1;
         bus_valid      <= 1'b0;
         bus_we         <= 1'b0;
         bus_addr       <= '0;
         bus_wdata      <= '0;
         memory_load    <= '0;
         memory_load_en <= 1'b0;
         done           <= 1'b0;
         reg_q          <= '0;
      end else begin
         req_ready      <= (state_next == IDLE);
         bus_valid      <= (state_next == BUS);
         memory_load_en <= (state_next == WB);
         done           <= store_retire || load_capture;
         if (accept) begin
            reg_q     <= req_reg;
            bus_addr  <= req_addr;
            bus_we    <= req_store;
            bus_wdata <= memory_store;
         end
         if (load_capture) begin
            memory_load <= bus_rdata;
         end
      end
   end

`ifdef MEM_UNIT_TIMEOUT_EN
   // Bus wait counter: cleared on entry to BUS, counts cycles without bus_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (state == BUS && !bus_ready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Fault pulse when the bus wait is abandoned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault <= 1'b0;
      end else begin
         fault <= timeout;
      end
   end
`else
   // No timeout hardware: fault never fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault <= 1'b0;
      end else begin
         fault <= timeout;
      end
   end
`endif

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit with a small register-file model and a
// writeback expectation queue.
module tb_mem_unit;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [3:0]  req_reg = 4'd0;
   logic [15:0] req_addr = 16'h0000;
   logic [3:0]  memory_index;
   logic [15:0] memory_load;
   logic        memory_load_en;
   logic [15:0] memory_store;
   logic        bus_valid;
   logic        bus_ready = 1'b0;
   logic        bus_we;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata = 16'h0000;
   logic        done;
   logic        fault;
   mem_state_t  state_dbg;

   int total = 0;
   int bad = 0;

   logic [15:0] rf [16];
   logic [15:0] exp_q [$];
   logic [15:0] exp_w;

   mem_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_reg(req_reg), .req_addr(req_addr),
      .memory_index(memory_index), .memory_load(memory_load),
      .memory_load_en(memory_load_en), .memory_store(memory_store),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .done(done), .fault(fault), .state_dbg(state_dbg)
   );

   // Clock.
   always #5 clk = ~clk;

   // Register file read port: index 0 reads as zero.
   assign memory_store = (memory_index == 4'd0) ? 16'h0000 : rf[memory_index];

   // Register file write port on negedge, checked against expected writebacks.
   always @(negedge clk) begin
      if (!rst && memory_load_en) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected: got write r%0d=%h, required none", memory_index, memory_load);
         end else begin
            exp_w = exp_q.pop_front();
            if (memory_load !== exp_w) begin
               bad++;
               $display("FAIL wb_data: got %h required %h", memory_load, exp_w);
            end
         end
         rf[memory_index] = memory_load;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic store, input logic [3:0] r, input logic [15:0] a);
      req_valid = 1'b1;
      req_store = store;
      req_reg   = r;
      req_addr  = a;
   endtask

   task automatic test_reset();
      req_reg = 4'd7;
      repeat (2) tick();
      total++;
      if ({req_ready, bus_valid, bus_we, memory_load_en, done, fault} !== 6'b100000) begin
         bad++;
         $display("FAIL reset_ctrl: got %b required 100000", {req_ready, bus_valid, bus_we, memory_load_en, done, fault});
      end
      total++;
      if ({bus_addr, bus_wdata, memory_load} !== 48'h0) begin
         bad++;
         $display("FAIL reset_data: got %h required 0", {bus_addr, bus_wdata, memory_load});
      end
      total++;
      if (memory_index !== 4'd7 || state_dbg !== IDLE) begin
         bad++;
         $display("FAIL reset_index: got idx=%0d state=%0d required idx=7 state=0", memory_index, state_dbg);
      end
      rst = 1'b0;
      bus_ready = 1'b1;
      repeat (2) tick();
      total++;
      if (bus_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL idle_ignores_ready: got valid=%b done=%b ready=%b required 0 0 1", bus_valid, done, req_ready);
      end
      bus_ready = 1'b0;
   endtask

   task automatic test_load_zero_wait();
      drive_req(1'b0, 4'd3, 16'h0040);
      #1;
      total++;
      if (memory_index !== 4'd3 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL load_accept: got idx=%0d ready=%b required 3 1", memory_index, req_ready);
      end
      tick();
      req_valid = 1'b0;
      exp_q.push_back(16'hBEEF);
      total++;
      if ({bus_valid, bus_we, req_ready, bus_addr} !== {3'b100, 16'h0040}) begin
         bad++;
         $display("FAIL load_bus: got v=%b we=%b rdy=%b addr=%h required 1 0 0 0040", bus_valid, bus_we, req_ready, bus_addr);
      end
      bus_ready = 1'b1;
      bus_rdata = 16'hBEEF;
      tick();
      bus_ready = 1'b0;
      bus_rdata = 16'h0000;
      total++;
      if ({memory_load_en, done, bus_valid, memory_index, memory_load} !== {3'b110, 4'd3, 16'hBEEF}) begin
         bad++;
         $display("FAIL load_wb: got en=%b done=%b v=%b idx=%0d data=%h required 1 1 0 3 beef",
                  memory_load_en, done, bus_valid, memory_index, memory_load);
      end
      tick();
      total++;
      if (memory_load_en !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1 || rf[3] !== 16'hBEEF) begin
         bad++;
         $display("FAIL load_retire: got en=%b done=%b rdy=%b r3=%h required 0 0 1 beef", memory_load_en, done, req_ready, rf[3]);
      end
   endtask

   task automatic test_store_wait();
      rf[5] = 16'h1234;
      drive_req(1'b1, 4'd5, 16'h0100);
      tick();
      req_valid = 1'b0;
      req_reg = 4'd9;
      total++;
      if (memory_index !== 4'd5) begin
         bad++;
         $display("FAIL store_index: got %0d required 5", memory_index);
      end
      for (int i = 1; i <= 4; i++) begin
         total++;
         if ({bus_valid, bus_we, done, bus_addr, bus_wdata} !== {3'b110, 16'h0100, 16'h1234}) begin
            bad++;
            $display("FAIL store_wait_c%0d: got v=%b we=%b done=%b addr=%h wdata=%h required 1 1 0 0100 1234",
                     i, bus_valid, bus_we, done, bus_addr, bus_wdata);
         end
         if (i == 2) rf[5] = 16'hFFFF;
         if (i == 4) bus_ready = 1'b1;
         tick();
      end
      bus_ready = 1'b0;
      total++;
      if ({done, bus_valid, memory_load_en, req_ready} !== 4'b1001) begin
         bad++;
         $display("FAIL store_done: got %b required 1001", {done, bus_valid, memory_load_en, req_ready});
      end
      tick();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL store_done_pulse: got %b required 0", done);
      end
   endtask

   task automatic test_store_r0();
      rf[0] = 16'h1111;
      drive_req(1'b1, 4'd0, 16'h0200);
      tick();
      req_valid = 1'b0;
      total++;
      if (bus_wdata !== 16'h0000 || bus_we !== 1'b1) begin
         bad++;
         $display("FAIL store_r0: got wdata=%h we=%b required 0000 1", bus_wdata, bus_we);
      end
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL store_r0_done: got %b required 1", done);
      end
      tick();
   endtask

   task automatic test_fetch();
      drive_req(1'b0, 4'd0, 16'h0010);
      tick();
      req_valid = 1'b0;
      exp_q.push_back(16'hA55A);
      bus_ready = 1'b1;
      bus_rdata = 16'hA55A;
      tick();
      bus_ready = 1'b0;
      total++;
      if ({memory_load_en, done, memory_index, memory_load} !== {2'b11, 4'd0, 16'hA55A}) begin
         bad++;
         $display("FAIL fetch_wb: got en=%b done=%b idx=%0d data=%h required 1 1 0 a55a",
                  memory_load_en, done, memory_index, memory_load);
      end
      tick();
      total++;
      if (rf[0] !== 16'hA55A) begin
         bad++;
         $display("FAIL fetch_ir: got %h required a55a", rf[0]);
      end
   endtask

   task automatic test_back_to_back();
      rf[1] = 16'h0101;
      rf[2] = 16'h0202;
      bus_ready = 1'b1;
      drive_req(1'b1, 4'd1, 16'h0010);
      tick();
      req_reg = 4'd2;
      req_addr = 16'h0011;
      tick();
      total++;
      if (done !== 1'b1 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first: got done=%b rdy=%b required 1 1", done, req_ready);
      end
      tick();
      req_valid = 1'b0;
      total++;
      if ({bus_valid, done, bus_addr, bus_wdata} !== {2'b10, 16'h0011, 16'h0202}) begin
         bad++;
         $display("FAIL b2b_second: got v=%b done=%b addr=%h wdata=%h required 1 0 0011 0202",
                  bus_valid, done, bus_addr, bus_wdata);
      end
      tick();
      bus_ready = 1'b0;
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_done: got %b required 1", done);
      end
      tick();
   endtask

   task automatic test_reset_mid_bus();
      rf[6] = 16'h6666;
      drive_req(1'b0, 4'd6, 16'h0030);
      tick();
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      total++;
      if (bus_valid !== 1'b0 || req_ready !== 1'b1 || state_dbg !== IDLE) begin
         bad++;
         $display("FAIL rst_mid_bus: got v=%b rdy=%b state=%0d required 0 1 0", bus_valid, req_ready, state_dbg);
      end
      bus_ready = 1'b1;
      bus_rdata = 16'hDEAD;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (memory_load_en !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_no_retire_c%0d: got en=%b done=%b required 0 0", i, memory_load_en, done);
         end
      end
      bus_ready = 1'b0;
      bus_rdata = 16'h0000;
      total++;
      if (rf[6] !== 16'h6666) begin
         bad++;
         $display("FAIL rst_r6: got %h required 6666", rf[6]);
      end
   endtask

`ifdef MEM_UNIT_TIMEOUT_EN
   task automatic test_timeout();
      drive_req(1'b0, 4'd4, 16'h0050);
      tick();
      req_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         total++;
         if ({bus_valid, fault, done} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_wait_c%0d: got %b required 100", i, {bus_valid, fault, done});
         end
         tick();
      end
      total++;
      if ({fault, bus_valid, done, req_ready} !== 4'b1001) begin
         bad++;
         $display("FAIL timeout_fault: got %b required 1001", {fault, bus_valid, done, req_ready});
      end
      drive_req(1'b1, 4'd1, 16'h0060);
      tick();
      req_valid = 1'b0;
      total++;
      if (bus_valid !== 1'b1 || fault !== 1'b0) begin
         bad++;
         $display("FAIL timeout_next_req: got v=%b fault=%b required 1 0", bus_valid, fault);
      end
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL timeout_next_done: got %b required 1", done);
      end
      tick();
   endtask
`else
   task automatic test_long_wait();
      drive_req(1'b0, 4'd4, 16'h0050);
      tick();
      req_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         total++;
         if ({bus_valid, fault, done} !== 3'b100) begin
            bad++;
            $display("FAIL long_wait_c%0d: got %b required 100", i, {bus_valid, fault, done});
         end
         tick();
      end
      exp_q.push_back(16'h4444);
      bus_ready = 1'b1;
      bus_rdata = 16'h4444;
      tick();
      bus_ready = 1'b0;
      total++;
      if ({memory_load_en, done, fault} !== 3'b110) begin
         bad++;
         $display("FAIL long_wait_done: got %b required 110", {memory_load_en, done, fault});
      end
      tick();
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
      test_reset();
      test_load_zero_wait();
      test_store_wait();
      test_store_r0();
      test_fetch();
      test_back_to_back();
      test_reset_mid_bus();
`ifdef MEM_UNIT_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL wb_missing: got %0d pending writebacks required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
